// File: rtl/frame_block_reader_if.sv
// frame_block_reader_if: memory port, block request, line handoff and geometry signals.
// slave is the reader side; master is the surrounding memory/consumer/controller side.
interface frame_block_reader_if #(
   parameter int MEM_WIDTH  = 64,
   parameter int PIX_WIDTH  = 8,
   parameter int BLK_SIZE   = 16,
   parameter int ADDR_WIDTH = 21,
   parameter int DIM_WIDTH  = 12
);
   logic [ADDR_WIDTH-1:0]         out_addr;
   logic                          mem_rd;
   logic [MEM_WIDTH-1:0]          in_data;
   logic [10:0]                   x;
   logic [10:0]                   y;
   logic                          read_block;
   logic                          busy;
   logic [BLK_SIZE*PIX_WIDTH-1:0] blk_line;
   logic [$clog2(BLK_SIZE)-1:0]   blk_line_idx;
   logic                          blk_line_rdy;
   logic                          blk_line_take;
   logic                          blk_done;
   logic                          blk_err;
   logic [DIM_WIDTH-1:0]          stride_in;
   logic [DIM_WIDTH-1:0]          width_in;
   logic [DIM_WIDTH-1:0]          height_in;
   logic                          setup_frame;
   modport slave (
      output out_addr, mem_rd, busy, blk_line, blk_line_idx, blk_line_rdy, blk_done, blk_err,
      input  in_data, x, y, read_block, blk_line_take, stride_in, width_in, height_in, setup_frame
   );
   modport master (
      input  out_addr, mem_rd, busy, blk_line, blk_line_idx, blk_line_rdy, blk_done, blk_err,
      output in_data, x, y, read_block, blk_line_take, stride_in, width_in, height_in, setup_frame
   );
endinterface

// File: rtl/frame_block_reader.sv
// frame_block_reader: fetches a block line by line from frame memory and hands lines out over valid/take.
// Optional edge clamping/padding and request rejection via FRAME_BLOCK_READER_EDGE_PAD_EN.
module frame_block_reader #(
   parameter int MEM_WIDTH  = 64,
   parameter int PIX_WIDTH  = 8,
   parameter int BLK_SIZE   = 16,
   parameter int ADDR_WIDTH = 21,
   parameter int DIM_WIDTH  = 12
) (
   input logic clk,
   input logic reset,
   frame_block_reader_if.slave bus
);
   localparam int LINE_W = BLK_SIZE*PIX_WIDTH;
   localparam int BEATS  = LINE_W/MEM_WIDTH;
   localparam int IDX_W  = $clog2(BLK_SIZE);
   localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
   typedef enum logic [2:0] {IDLE, ADDR, FETCH, CAPT, HOLD} state_t;
   state_t                state_q;
   logic [10:0]           x_q, y_q;
   logic [IDX_W-1:0]      row_q, idx_q;
   logic [BEAT_W-1:0]     beat_q, cap_q;
   logic [DIM_WIDTH-1:0]  stride_q, req_stride_q;
   logic [ADDR_WIDTH-1:0] addr_q, base;
   logic [LINE_W-1:0]     line_q, asm_line, cap_line;
   logic                  rd_q, rd_d_q, busy_q, rdy_q, done_q, reject;
   logic [63:0]           row_abs, row_eff;
   assign row_abs = 64'(y_q)*64'(BLK_SIZE) + 64'(row_q);
   assign base    = ADDR_WIDTH'(row_eff*64'(req_stride_q) + 64'(x_q)*64'(BEATS));
   always_comb begin
      asm_line = line_q;
      asm_line[cap_q*MEM_WIDTH +: MEM_WIDTH] = bus.in_data;
   end
`ifdef FRAME_BLOCK_READER_EDGE_PAD_EN
   logic [DIM_WIDTH-1:0] width_q, height_q, req_w_q, req_h_q;
   logic                 err_q;
   logic [63:0]          lim;
   logic [IDX_W-1:0]     pad_idx;
   assign reject  = 64'(bus.x)*64'(BLK_SIZE) >= 64'(width_q) || 64'(bus.y)*64'(BLK_SIZE) >= 64'(height_q);
   assign row_eff = row_abs >= 64'(req_h_q) ? 64'(req_h_q) - 64'd1 : row_abs;
   // lim = pixels of this line inside the frame; always >= 1 for an accepted request
   assign lim     = 64'(req_w_q) - 64'(x_q)*64'(BLK_SIZE);
   assign pad_idx = IDX_W'(lim - 64'd1);
   always_comb begin
      cap_line = asm_line;
      for (int p = 0; p < BLK_SIZE; p++)
         if (64'(p) >= lim) cap_line[p*PIX_WIDTH +: PIX_WIDTH] = asm_line[pad_idx*PIX_WIDTH +: PIX_WIDTH];
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         width_q  <= '0;
         height_q <= '0;
         req_w_q  <= '0;
         req_h_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= state_q == IDLE && bus.read_block && reject;
         if (state_q == IDLE && bus.read_block) begin
            req_w_q <= width_q;
            req_h_q <= height_q;
         end
         if (state_q == IDLE && bus.setup_frame) begin
            width_q  <= bus.width_in;
            height_q <= bus.height_in;
         end
      end
   assign bus.blk_err = err_q;
`else
   assign reject      = 1'b0;
   assign row_eff     = row_abs;
   assign cap_line    = asm_line;
   assign bus.blk_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         row_q        <= '0;
         idx_q        <= '0;
         beat_q       <= '0;
         cap_q        <= '0;
         stride_q     <= '0;
         req_stride_q <= '0;
         addr_q       <= '0;
         line_q       <= '0;
         rd_q         <= 1'b0;
         rd_d_q       <= 1'b0;
         busy_q       <= 1'b0;
         rdy_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         rd_d_q <= rd_q;
         done_q <= 1'b0;
         // memory data lands one cycle after each read strobe
         if (rd_d_q) begin
            line_q <= state_q == CAPT ? cap_line : asm_line;
            cap_q  <= cap_q + 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (bus.setup_frame) stride_q <= bus.stride_in;
               if (bus.read_block && !reject) begin
                  x_q          <= bus.x;
                  y_q          <= bus.y;
                  row_q        <= '0;
                  req_stride_q <= stride_q;
                  busy_q       <= 1'b1;
                  state_q      <= ADDR;
               end
            end
            ADDR: begin
               addr_q  <= base;
               rd_q    <= 1'b1;
               beat_q  <= '0;
               cap_q   <= '0;
               state_q <= FETCH;
            end
            FETCH:
               if (beat_q == BEAT_W'(BEATS-1)) begin
                  rd_q    <= 1'b0;
                  state_q <= CAPT;
               end else begin
                  beat_q <= beat_q + 1'b1;
                  addr_q <= addr_q + 1'b1;
               end
            CAPT: begin
               rdy_q   <= 1'b1;
               idx_q   <= row_q;
               state_q <= HOLD;
            end
            HOLD:
               if (bus.blk_line_take) begin
                  rdy_q <= 1'b0;
                  if (row_q == IDX_W'(BLK_SIZE-1)) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     row_q   <= row_q + 1'b1;
                     state_q <= ADDR;
                  end
               end
            default: state_q <= IDLE;
         endcase
      end
   assign bus.out_addr     = addr_q;
   assign bus.mem_rd       = rd_q;
   assign bus.busy         = busy_q;
   assign bus.blk_line     = line_q;
   assign bus.blk_line_idx = idx_q;
   assign bus.blk_line_rdy = rdy_q;
   assign bus.blk_done     = done_q;
endmodule

// File: tb/tb_frame_block_reader.sv
// tb_frame_block_reader: directed and randomized stimulus against a timeline/arithmetic model of the reader.
`timescale 1ns/1ps
module tb_frame_block_reader;
   localparam int MW = 64, PW = 8, BS = 16, AW = 21, DW = 12;
   localparam int LW = BS*PW, BEATS = LW/MW;
`ifdef FRAME_BLOCK_READER_EDGE_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   frame_block_reader_if #(.MEM_WIDTH(MW), .PIX_WIDTH(PW), .BLK_SIZE(BS), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus ();
   frame_block_reader #(.MEM_WIDTH(MW), .PIX_WIDTH(PW), .BLK_SIZE(BS), .ADDR_WIDTH(AW), .DIM_WIDTH(DW))
      dut (.clk(clk), .reset(rst_n), .bus(bus));
   always #5 clk = ~clk;
   int total = 0, bad = 0, done_cnt = 0;
   bit hash_mem = 1'b0;
   logic [AW-1:0] addr_log[$];
   function automatic logic [MW-1:0] word(logic [AW-1:0] a);
      return hash_mem ? (64'(a) * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF : 64'(a);
   endfunction
   always @(posedge clk) if (bus.mem_rd) bus.in_data <= word(bus.out_addr);
   task automatic chk(string n, logic [LW-1:0] a, logic [LW-1:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
      end
   endtask
   // model: geometry, request snapshot, and line timeline relative to the edge that started each line
   int g_s = 0, g_w = 0, g_h = 0, rx = 0, ry = 0, rs = 0, rw = 0, rh = 0, r = 0;
   bit act = 1'b0, e_busy = 1'b0, e_rd = 1'b0, e_rdy = 1'b0, e_done = 1'b0, e_err = 1'b0;
   longint cyc = 0, s = 0, c = 0;
   logic [AW-1:0] e_addr = '0;
   logic [LW-1:0] e_line = '0;
   function automatic longint base_of(int row);
      longint ra = longint'(ry)*BS + row;
      if (PAD && ra >= rh) ra = rh - 1;
      return ra*rs + longint'(rx)*BEATS;
   endfunction
   function automatic logic [LW-1:0] model_line(int row);
      logic [LW-1:0] l;
      longint lim = rw - longint'(rx)*BS;
      for (int k = 0; k < BEATS; k++) l[k*MW +: MW] = word(AW'(base_of(row) + k));
      if (PAD)
         for (int p = 0; p < BS; p++)
            if (p >= lim) l[p*PW +: PW] = l[(lim-1)*PW +: PW];
      return l;
   endfunction
   always @(posedge clk) begin
      if (!rst_n) begin
         act = 0; g_s = 0; g_w = 0; g_h = 0;
         e_busy = 0; e_rd = 0; e_rdy = 0; e_done = 0; e_err = 0;
      end else begin
         e_done = 0;
         e_err = 0;
         if (!act) begin
            if (bus.read_block) begin
               if (PAD && (int'(bus.x)*BS >= g_w || int'(bus.y)*BS >= g_h)) e_err = 1;
               else begin
                  act = 1; r = 0; s = cyc;
                  rx = int'(bus.x); ry = int'(bus.y); rs = g_s; rw = g_w; rh = g_h;
               end
            end
            if (bus.setup_frame) begin
               g_s = int'(bus.stride_in); g_w = int'(bus.width_in); g_h = int'(bus.height_in);
            end
         end else if (e_rdy && bus.blk_line_take) begin
            if (r == BS-1) begin act = 0; e_done = 1; end
            else begin r++; s = cyc; end
         end
         c = cyc + 1 - s;
         e_busy = act;
         e_rd   = act && c >= 2 && c <= BEATS+1;
         e_addr = AW'(base_of(r) + c - 2);
         e_rdy  = act && c >= BEATS+3;
         if (e_rdy) e_line = model_line(r);
      end
      cyc++;
   end
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_busy", LW'(bus.busy), '0);
         chk("rst_mem_rd", LW'(bus.mem_rd), '0);
         chk("rst_rdy", LW'(bus.blk_line_rdy), '0);
         chk("rst_done", LW'(bus.blk_done), '0);
         chk("rst_err", LW'(bus.blk_err), '0);
         chk("rst_addr", LW'(bus.out_addr), '0);
         chk("rst_line", bus.blk_line, '0);
         chk("rst_idx", LW'(bus.blk_line_idx), '0);
      end else begin
         chk("busy", LW'(bus.busy), LW'(e_busy));
         chk("mem_rd", LW'(bus.mem_rd), LW'(e_rd));
         chk("rdy", LW'(bus.blk_line_rdy), LW'(e_rdy));
         chk("done", LW'(bus.blk_done), LW'(e_done));
         chk("err", LW'(bus.blk_err), LW'(e_err));
         if (e_rd) chk("addr", LW'(bus.out_addr), LW'(e_addr));
         if (e_rdy) begin
            chk("line", bus.blk_line, e_line);
            chk("idx", LW'(bus.blk_line_idx), LW'(r));
         end
         if (bus.mem_rd) addr_log.push_back(bus.out_addr);
         if (bus.blk_done) done_cnt++;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic setup(int st, int w, int h);
      bus.stride_in = DW'(st); bus.width_in = DW'(w); bus.height_in = DW'(h);
      bus.setup_frame = 1'b1;
      tick();
      bus.setup_frame = 1'b0;
   endtask
   task automatic request(int xx, int yy);
      bus.x = 11'(xx); bus.y = 11'(yy);
      bus.read_block = 1'b1;
      tick();
      bus.read_block = 1'b0;
   endtask
   task automatic wait_rdy();
      int k = 0;
      while (!bus.blk_line_rdy && k < 100) begin tick(); k++; end
      if (!bus.blk_line_rdy) begin total++; bad++; $display("FAIL rdy_timeout got=0 want=1 t=%0t", $time); end
   endtask
   task automatic take();
      bus.blk_line_take = 1'b1;
      tick();
      bus.blk_line_take = 1'b0;
   endtask
   task automatic take_lines(int n);
      for (int i = 0; i < n; i++) begin wait_rdy(); take(); end
   endtask
   initial begin
      int n, sz;
      logic [MW-1:0] w0;
      bus.x = '0; bus.y = '0; bus.read_block = 0; bus.blk_line_take = 0;
      bus.stride_in = '0; bus.width_in = '0; bus.height_in = '0; bus.setup_frame = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      // address sequence, assembly and backpressure with word = address
      setup(100, 1920, 1080);
      addr_log.delete(); done_cnt = 0;
      request(2, 1);
      n = 1;
      while (!bus.blk_line_rdy && n < 50) begin tick(); n++; end
      chk("first_rdy_cycle", LW'(n), LW'(5));
      chk("l0_beat0", LW'(bus.blk_line[63:0]), LW'(1604));
      chk("l0_beat1", LW'(bus.blk_line[127:64]), LW'(1605));
      for (int i = 0; i < BS; i++) begin
         wait_rdy();
         if (i == 3) begin
            sz = addr_log.size();
            bus.stride_in = DW'(7); bus.setup_frame = 1'b1; bus.read_block = 1'b1;
            repeat (10) tick();
            bus.setup_frame = 1'b0; bus.read_block = 1'b0;
            chk("hold_idx", LW'(bus.blk_line_idx), LW'(3));
            chk("hold_no_rd", LW'(addr_log.size()), LW'(sz));
         end
         take();
      end
      tick();
      chk("rd_pulses", LW'(addr_log.size()), LW'(32));
      chk("done_pulses", LW'(done_cnt), LW'(1));
      chk("l0_addr0", LW'(addr_log[0]), LW'(1604));
      chk("l0_addr1", LW'(addr_log[1]), LW'(1605));
      chk("l15_addr0", LW'(addr_log[30]), LW'(3104));
      chk("l15_addr1", LW'(addr_log[31]), LW'(3105));
      // stride 7 was offered only while busy, so stride 100 still applies
      addr_log.delete();
      request(0, 0);
      take_lines(BS);
      tick();
      chk("old_stride", LW'(addr_log[2]), LW'(100));
      // reset while fetching line 5
      setup(100, 1920, 1080);
      request(2, 1);
      take_lines(5);
      n = 0;
      while (!bus.mem_rd && n < 20) begin tick(); n++; end
      rst_n = 1'b0;
      #1;
      chk("rst_now_rd", LW'(bus.mem_rd), '0);
      chk("rst_now_busy", LW'(bus.busy), '0);
      repeat (2) tick();
      rst_n = 1'b1;
      setup(100, 1920, 1080);
      addr_log.delete(); done_cnt = 0;
      request(2, 1);
      wait_rdy();
      chk("restart_idx", LW'(bus.blk_line_idx), '0);
      chk("restart_addr", LW'(addr_log[0]), LW'(1604));
      take_lines(BS);
      tick();
      chk("restart_done", LW'(done_cnt), LW'(1));
      hash_mem = 1'b1;
`ifdef FRAME_BLOCK_READER_EDGE_PAD_EN
      setup(100, 40, 20);
      addr_log.delete();
      request(2, 1);
      w0 = word(AW'(1604));
      for (int i = 0; i < BS; i++) begin
         wait_rdy();
         if (i == 0)
            for (int p = 8; p < BS; p++) chk("pad_pix", LW'(bus.blk_line[p*PW +: PW]), LW'(w0[63:56]));
         take();
      end
      tick();
      chk("clamp_row4", LW'(addr_log[8]), LW'(1904));
      chk("clamp_row15", LW'(addr_log[30]), LW'(1904));
      request(3, 1);
      chk("reject_err", LW'(bus.blk_err), LW'(1));
      chk("reject_busy", LW'(bus.busy), '0);
      tick();
      chk("reject_err_pulse", LW'(bus.blk_err), '0);
`endif
      for (int k = 0; k < 1500; k++) begin
         bus.read_block    = $urandom_range(0, 7) == 0;
         bus.x             = $urandom_range(0, 3) == 0 ? 11'($urandom) : 11'($urandom_range(0, 40));
         bus.y             = $urandom_range(0, 3) == 0 ? 11'($urandom) : 11'($urandom_range(0, 40));
         bus.setup_frame   = $urandom_range(0, 15) == 0;
         bus.stride_in     = DW'($urandom);
         bus.width_in      = DW'($urandom_range(16, 700));
         bus.height_in     = DW'($urandom_range(16, 700));
         bus.blk_line_take = $urandom_range(0, 2) == 0;
         tick();
      end
      bus.read_block = 1'b0; bus.setup_frame = 1'b0; bus.blk_line_take = 1'b1;
      n = 0;
      while (bus.busy && n < 400) begin tick(); n++; end
      if (bus.busy) begin total++; bad++; $display("FAIL drain_timeout got=1 want=0 t=%0t", $time); end
      bus.blk_line_take = 1'b0;
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/frame_block_reader.md
Name: frame_block_reader

Overview:
Parametrised successor to the frame buffer front end. It holds the frame geometry, accepts block-fetch requests in block coordinates, and generates word addresses for the frame memory. It assembles each block line from several memory beats and hands lines to the pixel loader over a valid/take handshake. It sits between the frame memory port and the block pixel loader.

Parameters:
MEM_WIDTH, 64, memory data width in bits.
PIX_WIDTH, 8, bits per pixel.
BLK_SIZE, 16, block edge in pixels (lines per block, pixels per line).
ADDR_WIDTH, 21, memory word address width.
DIM_WIDTH, 12, width of the stride, width and height fields.
Derived values:
- LINE_W = BLK_SIZE*PIX_WIDTH.
- BEATS = LINE_W/MEM_WIDTH. Must be an integer >= 1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
out_addr  out  ADDR_WIDTH  memory word address
mem_rd  out  1  read strobe; data returns exactly 1 cycle later
in_data  in  MEM_WIDTH  memory read data
x  in  11  block column
y  in  11  block row
read_block  in  1  request pulse; sampled only when busy=0
busy  out  1  request in progress
blk_line  out  LINE_W  assembled line; pixel 0 in the LSBs
blk_line_idx  out  log2(BLK_SIZE)  row index of blk_line within the block
blk_line_rdy  out  1  line valid; held until taken
blk_line_take  in  1  consumer takes the line while rdy=1
blk_done  out  1  one-cycle pulse when the last line is taken
blk_err  out  1  one-cycle pulse on a rejected request (EDGE_PAD_EN only)
stride_in  in  DIM_WIDTH  line stride in memory words
width_in  in  DIM_WIDTH  frame width in pixels
height_in  in  DIM_WIDTH  frame height in lines
setup_frame  in  1  latch geometry

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - all outputs are 0; blk_line, blk_line_idx and out_addr are 0.
  - stride, width and height registers are 0.
  - the FSM goes to IDLE.
  - Reset in mid-request abandons the request; no blk_done is issued.
- setup_frame latches stride_in, width_in and height_in only in IDLE. It is ignored while busy=1.
- If read_block and setup_frame coincide in IDLE, the request uses the old geometry; the new geometry applies to the next request.
- FSM states:
  - IDLE -> ADDR when read_block=1 is sampled. Latch x and y; set row=0; set busy=1.
  - ADDR: register line_base = (y*BLK_SIZE + row)*stride + x*BEATS. Computed full width, then truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH). -> FETCH.
  - FETCH: for BEATS consecutive cycles, mem_rd=1 and out_addr = line_base + beat. Beat 0 comes first.
  - Capture: in_data for beat k is sampled on the edge after its mem_rd cycle. It goes into bits [k*MEM_WIDTH +: MEM_WIDTH] of the line register. -> CAPT after the last beat is issued.
  - CAPT: one cycle for the last capture; then blk_line_rdy=1 and blk_line_idx=row. -> HOLD.
  - HOLD: blk_line and blk_line_idx stay stable while rdy=1.
    - On take with row < BLK_SIZE-1: rdy falls, row increments, -> ADDR.
    - On take with row = BLK_SIZE-1: rdy falls, blk_done pulses, busy falls in the same cycle, -> IDLE.
- Latency: read_block sampled at edge 0; mem_rd is high in cycles 2..BEATS+1; blk_line_rdy rises at cycle BEATS+3. After a take, the next rdy follows BEATS+3 cycles later. There is no prefetch.
- blk_line_take while rdy=0 is ignored.
- read_block while busy=1 is ignored and not queued.
- mem_rd is 0 in every state except FETCH.

Optional Feature:
Macro: FRAME_BLOCK_READER_EDGE_PAD_EN.
With the macro defined:
- A request with x*BLK_SIZE >= width or y*BLK_SIZE >= height is rejected. blk_err pulses the cycle after read_block; the FSM stays in IDLE and busy stays 0.
- For accepted requests, the effective row is min(y*BLK_SIZE + row, height-1).
- In the delivered line, each pixel p with x*BLK_SIZE + p >= width is replaced by the pixel at column width-1.
- Latency is unchanged; the padding is applied in CAPT.
Without the macro:
- blk_err is tied to 0.
- No clamping; width and height are latched but unused.

Test Plan:
- Address sequence: setup stride=100, width=1920, height=1080; read_block x=2, y=1 (BEATS=2) -> line 0 reads 1604, 1605; line 15 reads 3104, 3105; exactly 32 mem_rd pulses; blk_done pulses once.
- Backpressure: hold blk_line_take=0 for 10 cycles on line 3 -> blk_line and blk_line_idx=3 stay stable, no mem_rd; take -> next mem_rd follows 1 cycle later.
- Line assembly: memory returns word = address -> blk_line[63:0]=1604 and blk_line[127:64]=1605 for line 0; first rdy at cycle BEATS+3 = 5.
- Ignored inputs: read_block and setup_frame with stride=7 mid-request -> addresses keep stride 100; the next request uses the old stride unless setup is reapplied in IDLE.
- Reset: reset=0 during FETCH of line 5 -> mem_rd, busy and rdy go to 0 immediately; a new request after release starts at line 0.
- EDGE_PAD_EN: width=40, height=20, x=2, y=1 -> pixels 8..15 equal pixel 7; rows 4..15 repeat frame row 19; x=3 -> blk_err pulse, busy stays 0.
